// File: rtl/raisin64_pkg.sv
// Shared types and constants for the raisin64 instruction-fetch front end.
package raisin64_pkg;

   localparam logic [63:0] INST_NOP    = 64'h0;
   localparam int unsigned FETCH_BYTES = 8;

   typedef enum logic [1:0] {
      PF_IDLE,
      PF_REQ,
      PF_DRAIN
   } pf_state_t;

   // One prefetch queue entry: fetch address alongside the returned word.
   typedef struct packed {
      logic [63:0] addr;
      logic [63:0] data;
   } pf_entry_t;

endpackage

// File: rtl/pf_fifo.sv
// Small synchronous FIFO with flush; head is read straight from the storage array.
module pf_fifo #(
   parameter  int unsigned WIDTH = 128,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !flush;
   assign do_pop  = pop && !flush && (count != '0);

   // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (!do_push && do_pop) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // The issue logic upstream reserves a slot, so a full push is a design bug.
   always_ff @(posedge clk) begin
      if (rst_n && do_push) begin
         assert (count != CW'(DEPTH)) else $error("pf_fifo: push while full");
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch buffer: one outstanding imem request, queued fetch words,
// redirect flush with stale-response draining.
module inst_prefetch
   import raisin64_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [63:0] imem_addr,
   output logic        imem_addr_valid,
   input  logic [63:0] imem_data,
   input  logic        imem_data_valid,
   output logic [63:0] inst_data,
   output logic        inst_valid,
   output logic [63:0] next_jump_pc,
   input  logic [63:0] jump_pc,
   input  logic        do_jump,
   input  logic        stall
);

   localparam int unsigned CW   = $clog2(DEPTH + 1);
   localparam logic [63:0] STEP = 64'(FETCH_BYTES);

   pf_state_t   state;
   pf_state_t   state_nxt;
   logic [63:0] fetch_pc;
   logic [63:0] fetch_pc_nxt;
   logic [63:0] addr_nxt;
   logic        addr_valid_nxt;
   logic        push;
   logic        pop;
   logic        flush;
   logic [CW-1:0] count;
   logic [CW-1:0] count_after_pop;
   logic        empty;
   pf_entry_t   head;
   pf_entry_t   wentry;

   pf_fifo #(
      .WIDTH ($bits(pf_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (wentry),
      .head  (head),
      .count (count),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= PF_IDLE;
         fetch_pc        <= RESET_PC;
         imem_addr       <= RESET_PC;
         imem_addr_valid <= 1'b0;
      end else begin
         state           <= state_nxt;
         fetch_pc        <= fetch_pc_nxt;
         imem_addr       <= addr_nxt;
         imem_addr_valid <= addr_valid_nxt;
      end
   end

   // Request FSM; redirect outranks push/pop, which outrank a new issue.
   always_comb begin
      state_nxt       = state;
      fetch_pc_nxt    = fetch_pc;
      addr_nxt        = imem_addr;
      addr_valid_nxt  = imem_addr_valid;
      push            = 1'b0;
      flush           = do_jump;
      pop             = !stall && !empty && !do_jump;
      wentry          = '{addr: imem_addr, data: imem_data};
      count_after_pop = count - CW'(pop);

      if (do_jump) begin
         fetch_pc_nxt = jump_pc;
         if (state != PF_IDLE) begin
            if (imem_data_valid) begin
               state_nxt      = PF_IDLE;
               addr_valid_nxt = 1'b0;
            end else begin
               state_nxt      = PF_DRAIN;
            end
         end
      end else begin
         case (state)
            PF_IDLE: begin
               if (count_after_pop < CW'(DEPTH)) begin
                  addr_nxt       = fetch_pc;
                  addr_valid_nxt = 1'b1;
                  state_nxt      = PF_REQ;
               end
            end
            PF_REQ: begin
               if (imem_data_valid) begin
                  push           = 1'b1;
                  fetch_pc_nxt   = imem_addr + STEP;
                  addr_valid_nxt = 1'b0;
                  state_nxt      = PF_IDLE;
               end
            end
            PF_DRAIN: begin
               if (imem_data_valid) begin
                  addr_valid_nxt = 1'b0;
                  state_nxt      = PF_IDLE;
               end
            end
            default: state_nxt = PF_IDLE;
         endcase
      end
   end

   // Decode-facing view of the queue head; NOP and zero PC while empty.
   assign inst_valid   = !empty;
   assign inst_data    = empty ? INST_NOP : head.data;
   assign next_jump_pc = empty ? 64'h0 : head.addr + STEP;

endmodule

// File: tb/tb_inst_prefetch.sv
// Scoreboard bench for inst_prefetch: memory responder, stream model, directed and random phases.
module tb_inst_prefetch;
   import raisin64_pkg::*;

   localparam int unsigned DEPTH    = 4;
   localparam logic [63:0] RESET_PC = 64'h1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] imem_addr;
   logic        imem_addr_valid;
   logic [63:0] imem_data;
   logic        imem_data_valid;
   logic [63:0] inst_data;
   logic        inst_valid;
   logic [63:0] next_jump_pc;
   logic [63:0] jump_pc;
   logic        do_jump;
   logic        stall;

   int n_checks = 0;
   int n_pass   = 0;
   int n_acc    = 0;
   int mem_lat  = 2;
   bit rand_lat = 1'b0;

   logic [63:0] exp_q   [$];
   logic [63:0] req_log [$];

   inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_addr       (imem_addr),
      .imem_addr_valid (imem_addr_valid),
      .imem_data       (imem_data),
      .imem_data_valid (imem_data_valid),
      .inst_data       (inst_data),
      .inst_valid      (inst_valid),
      .next_jump_pc    (next_jump_pc),
      .jump_pc         (jump_pc),
      .do_jump         (do_jump),
      .stall           (stall)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] word(input logic [63:0] a);
      return {a[31:0] ^ 32'hC0DE_F00D, a[63:32] ^ a[34:3]};
   endfunction

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endfunction

   // Decode should see consecutive fetch addresses from the last restart point.
   function automatic void restart_stream(input logic [63:0] pc);
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(pc + 64'(8 * i));
   endfunction

   function automatic logic [63:0] log_at(input int i);
      return (i < req_log.size()) ? req_log[i] : 64'hDEAD_DEAD_DEAD_DEAD;
   endfunction

   // Memory model: answers each request after a latency, checks request stability.
   logic        have_req = 1'b0;
   logic [63:0] req_addr;
   int          lat_left;
   always @(posedge clk) begin
      #1;
      imem_data_valid = 1'b0;
      if (!imem_addr_valid) begin
         have_req = 1'b0;
      end else begin
         if (!have_req) begin
            have_req = 1'b1;
            req_addr = imem_addr;
            req_log.push_back(imem_addr);
            lat_left = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
            check("req_align", {61'h0, imem_addr[2:0]}, 64'h0);
         end else begin
            check("req_stable", imem_addr, req_addr);
         end
         if (lat_left <= 1) begin
            imem_data_valid = 1'b1;
            imem_data       = word(req_addr);
            have_req        = 1'b0;
         end else begin
            lat_left--;
         end
      end
   end

   // Monitor: every accepted instruction must be the next expected stream entry.
   bit          chk_flush = 1'b0;
   logic [63:0] mon_addr;
   always @(negedge clk) begin
      if (!rst_n) begin
         chk_flush = 1'b0;
      end else begin
         if (chk_flush) begin
            check("flush_inst_valid", 64'(inst_valid), 64'h0);
            check("flush_inst_data", inst_data, 64'h0);
            check("flush_next_pc", next_jump_pc, 64'h0);
         end
         chk_flush = do_jump;
         if (inst_valid && !stall && !do_jump) begin
            n_acc++;
            if (exp_q.size() == 0) begin
               check("stream_nonempty", 64'h0, 64'h1);
            end else begin
               mon_addr = exp_q.pop_front();
               check("stream_data", inst_data, word(mon_addr));
               check("stream_next_pc", next_jump_pc, mon_addr + 64'd8);
               if (exp_q.size() == 0) exp_q.push_back(mon_addr + 64'd8);
               else exp_q.push_back(exp_q[$] + 64'd8);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input int cycles);
      rst_n   = 1'b0;
      do_jump = 1'b0;
      restart_stream(RESET_PC);
      repeat (cycles) tick();
      req_log.delete();
   endtask

   task automatic wait_req(input string name, input int n, input int budget);
      for (int i = 0; i < budget && req_log.size() < n; i++) tick();
      check(name, 64'(req_log.size() >= n), 64'h1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_imem_addr"}, imem_addr, RESET_PC);
      check({tag, "_imem_addr_valid"}, 64'(imem_addr_valid), 64'h0);
      check({tag, "_inst_valid"}, 64'(inst_valid), 64'h0);
      check({tag, "_inst_data"}, inst_data, 64'h0);
      check({tag, "_next_jump_pc"}, next_jump_pc, 64'h0);
   endtask

   initial begin
      logic [63:0] jpc;
      int i;
      rst_n   = 1'b0;
      stall   = 1'b0;
      do_jump = 1'b0;
      jump_pc = 64'h0;
      imem_data = 64'h0;
      imem_data_valid = 1'b0;
      restart_stream(RESET_PC);

      // Reset values and first fetch with 2-cycle memory.
      mem_lat = 2;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      req_log.delete();
      tick();
      check("first_req_valid", 64'(imem_addr_valid), 64'h1);
      check("first_req_addr", imem_addr, 64'h1000);
      for (i = 0; i < 20 && !inst_valid; i++) tick();
      check("first_inst_valid", 64'(inst_valid), 64'h1);
      check("first_inst_data", inst_data, word(64'h1000));
      check("first_next_pc", next_jump_pc, 64'h1008);
      wait_req("second_req_seen", 2, 20);
      check("req0_addr", log_at(0), 64'h1000);
      check("req1_addr", log_at(1), 64'h1008);

      // Back-pressure: stalled decode with 1-cycle memory fills exactly DEPTH entries.
      stall   = 1'b1;
      mem_lat = 1;
      do_reset(2);
      rst_n = 1'b1;
      repeat (20) tick();
      check("bp_req_count", 64'(req_log.size()), 64'(DEPTH));
      for (int k = 0; k < 4; k++) check("bp_req_addr", log_at(k), 64'h1000 + 64'(8 * k));
      check("bp_idle", 64'(imem_addr_valid), 64'h0);
      check("bp_head_valid", 64'(inst_valid), 64'h1);
      check("bp_head_data", inst_data, word(64'h1000));
      stall = 1'b0;
      for (int k = 1; k < 4; k++) begin
         tick();
         check("bp_pop_order", inst_data, word(64'h1000 + 64'(8 * k)));
      end

      // Redirect while 0x1010 is outstanding.
      stall   = 1'b0;
      mem_lat = 3;
      do_reset(2);
      rst_n = 1'b1;
      for (i = 0; i < 60 && !(imem_addr_valid && imem_addr == 64'h1010); i++) tick();
      check("rd_pending_1010", 64'(imem_addr_valid && imem_addr == 64'h1010), 64'h1);
      do_jump = 1'b1;
      jump_pc = 64'h2000;
      restart_stream(64'h2000);
      req_log.delete();
      tick();
      do_jump = 1'b0;
      check("rd_inst_valid", 64'(inst_valid), 64'h0);
      check("rd_drain_valid", 64'(imem_addr_valid), 64'h1);
      check("rd_drain_addr", imem_addr, 64'h1010);
      wait_req("rd_new_req_seen", 1, 20);
      check("rd_new_req_addr", log_at(0), 64'h2000);
      repeat (20) tick();

      // Redirect coincident with a response.
      mem_lat = 2;
      do_reset(2);
      rst_n = 1'b1;
      for (i = 0; i < 40 && !(req_log.size() >= 2 && imem_data_valid); i++) tick();
      check("co_resp_seen", 64'(imem_data_valid), 64'h1);
      do_jump = 1'b1;
      jump_pc = 64'h3000;
      restart_stream(64'h3000);
      req_log.delete();
      tick();
      do_jump = 1'b0;
      check("co_idle", 64'(imem_addr_valid), 64'h0);
      tick();
      check("co_req_valid", 64'(imem_addr_valid), 64'h1);
      check("co_req_addr", imem_addr, 64'h3000);
      repeat (20) tick();

      // Redirect with stall and three queued entries.
      stall   = 1'b1;
      mem_lat = 1;
      do_reset(2);
      rst_n = 1'b1;
      wait_req("js_fill", 4, 40);
      check("js_queued", 64'(inst_valid), 64'h1);
      do_jump = 1'b1;
      jump_pc = 64'h4000;
      restart_stream(64'h4000);
      req_log.delete();
      tick();
      do_jump = 1'b0;
      stall   = 1'b0;
      check("js_inst_valid", 64'(inst_valid), 64'h0);
      check("js_inst_data", inst_data, 64'h0);
      wait_req("js_new_req_seen", 1, 20);
      check("js_new_req_addr", log_at(0), 64'h4000);
      repeat (20) tick();

      // Reset asserted while draining a stale request.
      mem_lat = 4;
      do_reset(2);
      rst_n = 1'b1;
      tick();
      do_jump = 1'b1;
      jump_pc = 64'h5000;
      restart_stream(64'h5000);
      tick();
      do_jump = 1'b0;
      check("dr_drain_valid", 64'(imem_addr_valid), 64'h1);
      check("dr_drain_addr", imem_addr, 64'h1000);
      rst_n = 1'b0;
      restart_stream(RESET_PC);
      tick();
      check_reset_outputs("dr_reset");
      rst_n = 1'b1;
      req_log.delete();
      tick();
      check("dr_restart_valid", 64'(imem_addr_valid), 64'h1);
      check("dr_restart_addr", imem_addr, RESET_PC);
      wait_req("dr_req_seen", 1, 5);
      check("dr_req_log", log_at(0), RESET_PC);
      repeat (10) tick();

      // Random stress: stalls, redirects (including near address wrap), rare resets.
      rand_lat = 1'b1;
      n_acc    = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         rst_n   = 1'b1;
         do_jump = 1'b0;
         stall   = ($urandom_range(0, 99) < 30);
         if ($urandom_range(0, 99) < 6) begin
            jpc = {32'($urandom), 32'($urandom)};
            jpc[2:0] = 3'b000;
            if ($urandom_range(0, 99) < 20) jpc = 64'hFFFF_FFFF_FFFF_FFE0;
            jump_pc = jpc;
            do_jump = 1'b1;
            restart_stream(jpc);
         end
         if ($urandom_range(0, 999) < 3) begin
            rst_n   = 1'b0;
            do_jump = 1'b0;
            restart_stream(RESET_PC);
         end
      end
      tick();
      rst_n   = 1'b1;
      do_jump = 1'b0;
      stall   = 1'b0;
      repeat (20) tick();
      check("stress_accepted", 64'(n_acc >= 200), 64'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
